// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types used by the line adapter and its fill buffer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [1:0]   lc3b_mem_wmask;
  typedef logic [127:0] lc3b_c_line;
  typedef logic [2:0]   lc3b_beat_idx;

  // Eight 16-bit words make one 128-bit cache line; the beat counter is 3 bits wide.
  localparam int WORDS_PER_LINE = 8;

endpackage

// File: rtl/line_buffer.sv
// Purpose: 128-bit line register that is loaded one 16-bit word at a time.
// Latency: a loaded word appears on line_q in the cycle after ld_en.
// Backpressure: none; a load is taken on every cycle that ld_en is high.
module line_buffer
  import lc3b_types::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_en,
  input  lc3b_beat_idx ld_idx,
  input  lc3b_word     ld_word,
  output lc3b_c_line   line_q
);

  lc3b_c_line line_d;

  // Replace only the addressed word and keep the others.
  always_comb begin
    line_d = line_q;
    if (ld_en) begin
      line_d[{ld_idx, 4'b0000} +: 16] = ld_word;
    end
  end

  // Line storage, cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

endmodule

// File: rtl/line_adapter.sv
// Purpose: performs a 128-bit line fill or writeback as eight 16-bit word beats. Define
//   LINE_ADAPTER_WRAP_EN for critical-word-first order, which starts at line_address[3:1].
// Latency: request seen in cycle 0; 1-cycle GAP after each beat except the last; line_resp
//   comes in cycle 16 with zero-wait memory, plus one cycle for each memory wait cycle.
// Backpressure: each beat holds its strobe until mem_resp; the cache holds its request until line_resp.
module line_adapter
  import lc3b_types::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          line_read,
  input  logic          line_write,
  input  logic [15:0]   line_address,
  input  lc3b_c_line    line_wdata,
  output lc3b_c_line    line_rdata,
  output logic          line_resp,
  output logic          mem_read,
  output logic          mem_write,
  output lc3b_word      mem_address,
  output lc3b_word      mem_wdata,
  output lc3b_mem_wmask mem_byte_enable,
  input  lc3b_word      mem_rdata,
  input  logic          mem_resp
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] READ_BEAT  = 3'd1;
  localparam logic [2:0] WRITE_BEAT = 3'd2;
  localparam logic [2:0] GAP        = 3'd3;
  localparam logic [2:0] DONE       = 3'd4;

  localparam lc3b_beat_idx LAST_BEAT = lc3b_beat_idx'(WORDS_PER_LINE - 1);

  logic [2:0]   state_q, state_d;
  lc3b_beat_idx count_q, count_d;
  lc3b_beat_idx start_q, start_d;
  logic [11:0]  base_q, base_d;
  logic         is_wr_q, is_wr_d;
  lc3b_c_line   wdata_q, wdata_d;
  lc3b_c_line   line_rdata_q, line_rdata_d;

  lc3b_beat_idx word_idx;
  lc3b_beat_idx req_start;
  lc3b_c_line   fill_line;
  logic         fill_ld;
  logic         beat_done;
  logic         unused_addr;

`ifdef LINE_ADAPTER_WRAP_EN
  assign req_start = line_address[3:1];
`else
  assign req_start = '0;
`endif
  // Offset bits that do not take part in address generation in this build.
  assign unused_addr = ^line_address[3:0];

  // Adding 3-bit values wraps the word index from 7 to 0 in critical-word-first order.
  assign word_idx        = start_q + count_q;
  assign mem_address     = {base_q, word_idx, 1'b0};
  assign mem_wdata       = wdata_q[{word_idx, 4'b0000} +: 16];
  assign mem_byte_enable = 2'b11;
  // The strobes depend on the state only, so an asynchronous reset drops them immediately.
  assign mem_read        = (state_q == READ_BEAT);
  assign mem_write       = (state_q == WRITE_BEAT);
  assign line_resp       = (state_q == DONE);
  assign line_rdata      = line_rdata_q;

  assign beat_done = (mem_read | mem_write) & mem_resp;
  assign fill_ld   = mem_read & mem_resp;

  line_buffer u_fill_buf (
    .clk     (clk),
    .rst     (reset),
    .ld_en   (fill_ld),
    .ld_idx  (word_idx),
    .ld_word (mem_rdata),
    .line_q  (fill_line)
  );

  // Beat sequencer: accept a request, step through the beats with a GAP after each one, then pulse DONE.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    start_d = start_q;
    base_d  = base_q;
    is_wr_d = is_wr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (line_write || line_read) begin
          state_d = line_write ? WRITE_BEAT : READ_BEAT;
          is_wr_d = line_write;
          count_d = '0;
          start_d = req_start;
          base_d  = line_address[15:4];
          wdata_d = line_wdata;
        end
      end
      READ_BEAT, WRITE_BEAT: begin
        if (beat_done) begin
          if (count_q == LAST_BEAT) begin
            state_d = DONE;
          end else begin
            count_d = count_q + 3'd1;
            state_d = GAP;
          end
        end
      end
      GAP:     state_d = is_wr_q ? WRITE_BEAT : READ_BEAT;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // On the last fill beat, merge the arriving word so that line_rdata is complete while DONE is active.
  always_comb begin
    line_rdata_d = line_rdata_q;
    if (fill_ld && (count_q == LAST_BEAT)) begin
      line_rdata_d = fill_line;
      line_rdata_d[{word_idx, 4'b0000} +: 16] = mem_rdata;
    end
  end

  // Control, latched request fields and output line register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      start_q      <= '0;
      base_q       <= '0;
      is_wr_q      <= 1'b0;
      wdata_q      <= '0;
      line_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      start_q      <= start_d;
      base_q       <= base_d;
      is_wr_q      <= is_wr_d;
      wdata_q      <= wdata_d;
      line_rdata_q <= line_rdata_d;
    end
  end

endmodule

// File: tb/tb_line_adapter.sv
// Scoreboard bench for line_adapter: expected beats and line completions are queued at issue time.
// A memory-model/monitor process checks each beat as it completes and each line_resp as it appears.
// Expected orders and data are written out by hand; the wrap order depends on LINE_ADAPTER_WRAP_EN.
module tb_line_adapter;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdat;
  } beat_t;

  typedef struct {
    int           cyc;
    logic [127:0] rd;
  } lexp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         line_read = 1'b0;
  logic         line_write = 1'b0;
  logic [15:0]  line_address = '0;
  logic [127:0] line_wdata = '0;
  logic [127:0] line_rdata;
  logic         line_resp;
  logic         mem_read;
  logic         mem_write;
  logic [15:0]  mem_address;
  logic [15:0]  mem_wdata;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_rdata = '0;
  logic         mem_resp = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int waits = 0;
  int wait_cnt = 0;
  bit prev_resp = 1'b0;
  logic [15:0] mem_base = 16'hA000;

  beat_t beat_q[$];
  lexp_t line_q[$];

  line_adapter dut (
    .clk             (clk),
    .reset           (reset),
    .line_read       (line_read),
    .line_write      (line_write),
    .line_address    (line_address),
    .line_wdata      (line_wdata),
    .line_rdata      (line_rdata),
    .line_resp       (line_resp),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model and monitor: answer the strobes after `waits` stall cycles and check each beat and line_resp.
  always @(negedge clk) begin
    beat_t b;
    lexp_t l;
    if (prev_resp) begin
      chk(!mem_read && !mem_write, "gap_strobes_low", {mem_read, mem_write}, 2'b00);
    end
    prev_resp = 1'b0;
    if (line_resp) begin
      if (line_q.size() == 0) begin
        chk(1'b0, "unexpected_line_resp", 1, 0);
      end else begin
        l = line_q.pop_front();
        chk(cyc == l.cyc, "line_resp_cycle", cyc, l.cyc);
        chk(line_rdata === l.rd, "line_rdata", line_rdata, l.rd);
      end
    end
    if (mem_read || mem_write) begin
      if (wait_cnt < waits) begin
        wait_cnt++;
        mem_resp = 1'b0;
      end else begin
        wait_cnt = 0;
        if (beat_q.size() == 0) begin
          chk(1'b0, "unexpected_beat", mem_address, 0);
        end else begin
          b = beat_q.pop_front();
          chk(mem_write == b.wr && mem_read == !b.wr, "beat_kind", {mem_read, mem_write}, {!b.wr, b.wr});
          chk(mem_address === b.addr, "beat_addr", mem_address, b.addr);
          chk(mem_byte_enable === 2'b11, "byte_enable", mem_byte_enable, 2'b11);
          if (b.wr) chk(mem_wdata === b.wdat, "beat_wdata", mem_wdata, b.wdat);
        end
        mem_resp  = 1'b1;
        mem_rdata = mem_base + {13'b0, mem_address[3:1]};
        prev_resp = 1'b1;
      end
    end else begin
      mem_resp = 1'b0;
      wait_cnt = 0;
    end
  end

  task automatic push_beat(input logic wr, input logic [15:0] addr, input logic [15:0] wdat);
    beat_t b;
    b.wr = wr; b.addr = addr; b.wdat = wdat;
    beat_q.push_back(b);
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [127:0] wd, input int lat, input logic [127:0] exp_rd);
    lexp_t l;
    line_read = rd; line_write = wr; line_address = addr; line_wdata = wd;
    l.cyc = cyc + lat; l.rd = exp_rd;
    line_q.push_back(l);
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    @(negedge clk);
    while (!line_resp && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(line_resp, name, n, budget);
    @(posedge clk); #1;
    line_read = 1'b0; line_write = 1'b0;
  endtask

  logic [127:0] line_a = {16'hA007, 16'hA006, 16'hA005, 16'hA004, 16'hA003, 16'hA002, 16'hA001, 16'hA000};
  logic [127:0] line_b = {16'hB007, 16'hB006, 16'hB005, 16'hB004, 16'hB003, 16'hB002, 16'hB001, 16'hB000};
  logic [127:0] wline  = {16'h00FF, 16'h00DA, 16'h00B6, 16'h0091, 16'h006D, 16'h0048, 16'h0024, 16'h0000};
  logic [127:0] bline  = {16'h8888, 16'h7777, 16'h6666, 16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111};
  logic [15:0]  wrap_order [8];

  initial begin
`ifdef LINE_ADAPTER_WRAP_EN
    wrap_order = '{16'h123A, 16'h123C, 16'h123E, 16'h1230, 16'h1232, 16'h1234, 16'h1236, 16'h1238};
`else
    wrap_order = '{16'h1230, 16'h1232, 16'h1234, 16'h1236, 16'h1238, 16'h123A, 16'h123C, 16'h123E};
`endif
    #12;
    chk(line_rdata === '0, "rst_line_rdata", line_rdata, 0);
    chk(line_resp === 1'b0, "rst_line_resp", line_resp, 0);
    chk(mem_read === 1'b0 && mem_write === 1'b0, "rst_strobes", {mem_read, mem_write}, 0);
    chk(mem_address === 16'h0, "rst_mem_address", mem_address, 0);
    chk(mem_wdata === 16'h0, "rst_mem_wdata", mem_wdata, 0);
    chk(mem_byte_enable === 2'b11, "rst_byte_enable", mem_byte_enable, 2'b11);
    @(posedge clk); #1;
    reset = 1'b0;

    // Zero-wait fill from 0x1230.
    waits = 0; mem_base = 16'hA000;
    for (int i = 0; i < 8; i++) push_beat(1'b0, 16'h1230 + 16'(2 * i), 16'h0);
    issue(1'b1, 1'b0, 16'h1230, '0, 16, line_a);
    wait_done(40, "read0_timeout");

    // Back-to-back writeback with 2 wait cycles; the inputs change after acceptance.
    waits = 2;
    for (int i = 0; i < 8; i++) push_beat(1'b1, 16'h4000 + 16'(2 * i), wline[16 * i +: 16]);
    issue(1'b0, 1'b1, 16'h4000, wline, 32, line_a);
    @(posedge clk); #1;
    line_address = 16'hFFFF; line_wdata = '1;
    wait_done(60, "write_timeout");

    // Read and write both requested: the write wins.
    waits = 1;
    for (int i = 0; i < 8; i++) push_beat(1'b1, 16'h2000 + 16'(2 * i), bline[16 * i +: 16]);
    issue(1'b1, 1'b1, 16'h2000, bline, 24, line_a);
    wait_done(60, "both_timeout");

    // Reset during beat 3 of a read.
    waits = 0;
    for (int i = 0; i < 8; i++) push_beat(1'b0, 16'h1230 + 16'(2 * i), 16'h0);
    issue(1'b1, 1'b0, 16'h1230, '0, 16, line_a);
    repeat (7) @(posedge clk);
    #2;
    chk(mem_read === 1'b1 && mem_address === 16'h1236, "beat3_active", {mem_read, mem_address}, {1'b1, 16'h1236});
    reset = 1'b1; line_read = 1'b0;
    #1;
    chk(mem_read === 1'b0 && mem_write === 1'b0, "abort_strobes_low", {mem_read, mem_write}, 0);
    chk(line_resp === 1'b0, "abort_no_resp", line_resp, 0);
    beat_q.delete();
    line_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    chk(line_rdata === '0, "abort_line_rdata", line_rdata, 0);
    repeat (20) @(posedge clk);
    #1;

    // A normal fill after the abort.
    mem_base = 16'hB000;
    for (int i = 0; i < 8; i++) push_beat(1'b0, 16'h5670 + 16'(2 * i), 16'h0);
    issue(1'b1, 1'b0, 16'h5670, '0, 16, line_b);
    wait_done(40, "read_after_abort_timeout");

    // Fill from 0x123A: critical-word-first order when wrap is enabled, otherwise linear order.
    mem_base = 16'hA000;
    for (int i = 0; i < 8; i++) push_beat(1'b0, wrap_order[i], 16'h0);
    issue(1'b1, 1'b0, 16'h123A, '0, 16, line_a);
    wait_done(40, "wrap_read_timeout");

    repeat (4) @(posedge clk);
    #1;
    chk(beat_q.size() == 0, "beats_drained", beat_q.size(), 0);
    chk(line_q.size() == 0, "lines_drained", line_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
